// File: rtl/serdes_link_ctrl.sv
// Bring-up and link-maintenance sequencer for one SERDES lane: ordered PLL and
// transceiver resets, reset-done/alignment qualification, error monitoring and bounded retry.
module serdes_link_ctrl #(
  parameter int unsigned PLL_RST_CYCLES  = 16,
  parameter int unsigned PLL_LOCK_CYCLES = 1024,
  parameter int unsigned TRX_RST_CYCLES  = 16,
  parameter int unsigned DONE_TIMEOUT    = 4096,
  parameter int unsigned ALIGN_STABLE    = 16,
  parameter int unsigned ALIGN_TIMEOUT   = 4096,
  parameter int unsigned ERR_WINDOW      = 256,
  parameter int unsigned ERR_THRESH      = 4,
  parameter int unsigned MAX_RETRIES     = 7
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        restart_i,
  input  logic        tx_reset_done_i,
  input  logic        rx_reset_done_i,
  input  logic        rx_byte_aligned_i,
  input  logic [7:0]  rx_not_in_table_i,
  input  logic [7:0]  rx_disp_err_i,
  input  logic        rx_buf_err_i,
  input  logic        tx_buf_err_i,
  output logic        pll_rst_o,
  output logic        trx_rst_o,
  output logic        link_up_o,
  output logic        fault_o,
  output logic [2:0]  state_o,
  output logic [7:0]  retry_cnt_o,
  output logic [15:0] err_total_o
);

  typedef enum logic [2:0] {
    RESET_PLL  = 3'd0,
    WAIT_PLL   = 3'd1,
    RESET_TRX  = 3'd2,
    WAIT_DONE  = 3'd3,
    WAIT_ALIGN = 3'd4,
    LINK_UP    = 3'd5,
    FAULT      = 3'd6
  } state_t;

  // Timer compares use "last cycle" values so each state lasts exactly N cycles.
  localparam logic [15:0] PLL_RST_LAST  = 16'(PLL_RST_CYCLES - 1);
  localparam logic [15:0] PLL_LOCK_LAST = 16'(PLL_LOCK_CYCLES - 1);
  localparam logic [15:0] TRX_RST_LAST  = 16'(TRX_RST_CYCLES - 1);
  localparam logic [15:0] DONE_LAST     = 16'(DONE_TIMEOUT - 1);
  localparam logic [15:0] ALIGN_LAST    = 16'(ALIGN_TIMEOUT - 1);
  localparam logic [15:0] STABLE_LAST   = 16'(ALIGN_STABLE - 1);
  localparam logic [15:0] WIN_LAST      = 16'(ERR_WINDOW - 1);
  localparam logic [15:0] THRESH        = 16'(ERR_THRESH);
  localparam logic [7:0]  RETRY_LIMIT   = 8'(MAX_RETRIES);

  state_t      state;
  state_t      nxt;
  logic [1:0]  tx_sync;
  logic [1:0]  rx_sync;
  logic        done;
  logic        err_cyc;
  logic        clean;
  logic        retry;
  logic        entry;
  logic [15:0] timer;
  logic [15:0] clean_cnt;
  logic [15:0] wcnt;
  logic [15:0] win_err;
  logic [15:0] win_err_nxt;
  logic [7:0]  retry_cnt;
  logic [15:0] err_total;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tx_sync <= '0;
      rx_sync <= '0;
    end else begin
      tx_sync <= {tx_sync[0], tx_reset_done_i};
      rx_sync <= {rx_sync[0], rx_reset_done_i};
    end
  end

  assign done    = tx_sync[1] & rx_sync[1];
  assign err_cyc = (|rx_not_in_table_i) | (|rx_disp_err_i) | rx_buf_err_i | tx_buf_err_i;
  assign clean   = rx_byte_aligned_i & ~err_cyc;

  // The first cycle of each window (wcnt == 0) starts a fresh tally, including its own error.
  assign win_err_nxt = ((wcnt == 16'd0) ? 16'd0 : win_err) + {15'd0, err_cyc};

  always_comb begin
    nxt   = state;
    retry = 1'b0;
    case (state)
      RESET_PLL:  if (timer == PLL_RST_LAST) nxt = WAIT_PLL;
      WAIT_PLL:   if (timer == PLL_LOCK_LAST) nxt = RESET_TRX;
      RESET_TRX:  if (timer == TRX_RST_LAST) nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (done) nxt = WAIT_ALIGN;
        else if (timer == DONE_LAST) retry = 1'b1;
      end
      WAIT_ALIGN: begin
        if (!done) retry = 1'b1;
        else if (clean && (clean_cnt == STABLE_LAST)) nxt = LINK_UP;
        else if (timer == ALIGN_LAST) retry = 1'b1;
      end
      LINK_UP: begin
        if (!rx_byte_aligned_i || !done || (win_err_nxt == THRESH)) retry = 1'b1;
      end
      FAULT:      nxt = FAULT;
      default:    nxt = RESET_PLL;
    endcase
    if (retry) nxt = (retry_cnt == RETRY_LIMIT) ? FAULT : RESET_PLL;
    if (restart_i) nxt = RESET_PLL;
  end

  // A restart re-enters RESET_PLL even from RESET_PLL, so it also counts as an entry.
  assign entry = restart_i | (nxt != state);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= RESET_PLL;
      timer       <= '0;
      clean_cnt   <= '0;
      wcnt        <= '0;
      win_err     <= '0;
      retry_cnt   <= '0;
      err_total   <= '0;
      pll_rst_o   <= 1'b1;
      trx_rst_o   <= 1'b1;
      link_up_o   <= 1'b0;
      fault_o     <= 1'b0;
    end else begin
      state <= nxt;

      if (entry) timer <= '0;
      else if (timer != 16'hFFFF) timer <= timer + 16'd1;

      if ((state != WAIT_ALIGN) || entry || !clean) clean_cnt <= '0;
      else clean_cnt <= clean_cnt + 16'd1;

      if ((state != LINK_UP) || entry) begin
        wcnt    <= '0;
        win_err <= '0;
      end else begin
        wcnt    <= (wcnt == WIN_LAST) ? 16'd0 : wcnt + 16'd1;
        win_err <= win_err_nxt;
      end

      if (restart_i) retry_cnt <= '0;
      else if (retry && (retry_cnt != RETRY_LIMIT)) retry_cnt <= retry_cnt + 8'd1;

      if (restart_i) err_total <= '0;
      else if ((state == LINK_UP) && err_cyc && (err_total != 16'hFFFF))
        err_total <= err_total + 16'd1;

      // Outputs are decoded from the next state so they change together with state_o.
      pll_rst_o <= (nxt == RESET_PLL) || (nxt == FAULT);
      trx_rst_o <= (nxt == RESET_PLL) || (nxt == WAIT_PLL) || (nxt == RESET_TRX) || (nxt == FAULT);
      link_up_o <= (nxt == LINK_UP);
      fault_o   <= (nxt == FAULT);
    end
  end

  assign state_o     = state;
  assign retry_cnt_o = retry_cnt;
  assign err_total_o = err_total;

endmodule

// File: doc/serdes_link_ctrl.md
Name: serdes_link_ctrl

Overview:
Bring-up and link-maintenance sequencer for one CC_SERDES lane. It drives the PLL and transceiver resets in order and waits for reset-done. It then qualifies comma/byte alignment and monitors 8b/10b code errors and buffer errors while the link is up. On failure it retries the full bring-up, up to a bounded count, then latches a fault.

Parameters:
PLL_RST_CYCLES, 16, cycles pll_rst_o is held asserted (>=1)
PLL_LOCK_CYCLES, 1024, fixed wait after PLL reset release before transceiver reset release (>=1)
TRX_RST_CYCLES, 16, extra cycles trx_rst_o is held after the PLL wait (>=1)
DONE_TIMEOUT, 4096, cycles allowed for both reset-done flags
ALIGN_STABLE, 16, consecutive clean aligned cycles required for link-up
ALIGN_TIMEOUT, 4096, cycles allowed to reach ALIGN_STABLE
ERR_WINDOW, 256, monitor window length in cycles
ERR_THRESH, 4, error cycles per window that force a retry (>=1)
MAX_RETRIES, 7, retries before FAULT (1..255)

Ports:
clk_i  in  1  controller clock (RX core clock domain)
rstn_i  in  1  asynchronous active-low reset
restart_i  in  1  single-cycle restart request
tx_reset_done_i  in  1  from SERDES; async, 2-FF synchronised internally
rx_reset_done_i  in  1  from SERDES; async, 2-FF synchronised internally
rx_byte_aligned_i  in  1  RX_BYTE_IS_ALIGNED_O, clk_i domain
rx_not_in_table_i  in  8  per-byte code error, clk_i domain
rx_disp_err_i  in  8  per-byte disparity error, clk_i domain
rx_buf_err_i  in  1  RX buffer error, clk_i domain
tx_buf_err_i  in  1  TX buffer error, clk_i domain
pll_rst_o  out  1  PLL_RESET_I drive, active high
trx_rst_o  out  1  TX_RESET_I/RX_RESET_I drive, active high
link_up_o  out  1  high only in LINK_UP
fault_o  out  1  high only in FAULT
state_o  out  3  encoded state
retry_cnt_o  out  8  retries since reset/restart
err_total_o  out  16  saturating count of error cycles seen in LINK_UP

Behaviour:
- All outputs are registered.
- Reset values: state RESET_PLL; pll_rst_o=1, trx_rst_o=1, link_up_o=0, fault_o=0; counters 0; synchroniser flops 0.
- One shared 16-bit timer is cleared on every state entry.
- err_cyc (a cycle counted as an error) = |rx_not_in_table_i or |rx_disp_err_i or rx_buf_err_i or tx_buf_err_i.
- done = both synchronised done flags high.
- States and encodings:
  - RESET_PLL=0: pll_rst_o=1, trx_rst_o=1. Exactly PLL_RST_CYCLES cycles, then WAIT_PLL.
  - WAIT_PLL=1: pll_rst_o=0, trx_rst_o=1. Exactly PLL_LOCK_CYCLES cycles, then RESET_TRX.
  - RESET_TRX=2: trx_rst_o=1. Exactly TRX_RST_CYCLES cycles, then WAIT_DONE.
  - WAIT_DONE=3: trx_rst_o=0. On done go to WAIT_ALIGN. If the timer reaches DONE_TIMEOUT without done, take a RETRY.
  - WAIT_ALIGN=4: a clean counter increments when rx_byte_aligned_i and !err_cyc; otherwise it clears to 0. When it reaches ALIGN_STABLE go to LINK_UP. If !done, or the timer reaches ALIGN_TIMEOUT, take a RETRY.
  - LINK_UP=5: link_up_o=1.
    - Window counter runs 0..ERR_WINDOW-1 and wraps; a per-window error counter is cleared at wrap.
    - Each err_cyc increments the per-window counter and err_total_o (err_total_o saturates at 0xFFFF).
    - Per-window count reaching ERR_THRESH takes a RETRY in the same cycle the threshold is reached.
    - !rx_byte_aligned_i or !done takes an immediate RETRY.
    - Errors in the wrap cycle count toward the new window.
  - FAULT=6: pll_rst_o=1, trx_rst_o=1, fault_o=1. Held until restart_i.
- RETRY action (a transition, not a state):
  - If retry_cnt == MAX_RETRIES, go to FAULT.
  - Otherwise increment retry_cnt and go to RESET_PLL.
- restart_i has priority over every other transition in any state: next state RESET_PLL, retry_cnt and err_total cleared.
- Reset asserted mid-sequence returns everything to reset values immediately (asynchronous).
- Output timing from rstn_i release or restart:
  - pll_rst_o falls after PLL_RST_CYCLES cycles.
  - trx_rst_o falls after PLL_RST_CYCLES+PLL_LOCK_CYCLES+TRX_RST_CYCLES cycles.
- done latency: 2 synchroniser cycles plus 1 state cycle.
- link_up_o rises 1 cycle after the ALIGN_STABLE-th clean cycle.

Test Plan:
1. Bench parameters: PLL_RST=4, PLL_LOCK=8, TRX_RST=4, ALIGN_STABLE=4, ERR_WINDOW=16, ERR_THRESH=2, MAX_RETRIES=2, timeouts 32. Stimulus: release rstn, both done flags high, aligned high, no errors. Response: pll_rst_o falls at cycle 4, trx_rst_o falls at cycle 16, link_up_o=1 by cycle 16+3+4+1=24, retry_cnt_o=0.
2. Alignment bounce: same parameters; aligned toggles every 3 cycles. Response: no link-up; retry at ALIGN_TIMEOUT. After 2 retries the next failure gives fault_o=1, state_o=6, retry_cnt_o=2, pll_rst_o=1.
3. LINK_UP errors: one err_cyc per window → link held, err_total_o increments by 1 per window. Two errors in one window (rx_disp_err_i=8'h01 then rx_buf_err_i) → link_up_o=0 and state_o=0 the next cycle, retry_cnt_o=1.
4. Window boundary: errors in cycle 15 and cycle 0 of the next window → no retry (counted in separate windows).
5. Restart and reset priority:
   - restart_i in FAULT → state_o=0, counters 0, full bring-up repeats with scenario-1 timing.
   - restart_i coincident with a timeout-retry → retry_cnt_o=0.
   - rstn_i asserted in LINK_UP → outputs at reset values immediately.
6. Loss of lock: rx_reset_done_i dropped while in LINK_UP → retry 3 cycles later (synchroniser latency).
